// File: rtl/mr16_timer_n.sv
// mr16_timer_n: multi-channel prescaled down-counting timer with per-channel
// gating, one-shot mode and vectored, acknowledged interrupts.
module mr16_timer_n #(
  parameter int TIMER_WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int PRE_WIDTH = 8
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic [CHANNELS-1:0] I_GATE,
  input  logic                I_CS,
  input  logic                I_WR,
  input  logic [4:0]          I_A,
  input  logic [15:0]         I_D,
  output logic [15:0]         O_D,
  output logic                O_INT,
  output logic [2:0]          O_VEC,
  input  logic                I_IACK
);
  logic [TIMER_WIDTH-1:0] reload [CHANNELS];
  logic [TIMER_WIDTH-1:0] count [CHANNELS];
  logic [PRE_WIDTH-1:0] pcnt [CHANNELS];
  logic [PRE_WIDTH-1:0] pre [CHANNELS];
  logic [CHANNELS-1:0] irq, run, ien, oneshot, gateen;
  logic [CHANNELS-1:0] sel, qual, tick, term, set_irq, ack;
  logic [2:0] ch;
  logic [1:0] rsel;
  logic we;
  logic [TIMER_WIDTH-1:0] wd;
  assign ch = I_A[4:2];
  assign rsel = I_A[1:0];
  assign we = I_CS & I_WR;
  assign wd = I_D[TIMER_WIDTH-1:0];
  assign O_INT = |irq;
  always_comb begin
    O_VEC = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (irq[i]) O_VEC = 3'(i);
  end
  // A COUNT write discards a coincident tick, so it also suppresses the terminal event.
  always_comb begin
    sel = '0;
    qual = '0;
    tick = '0;
    term = '0;
    set_irq = '0;
    ack = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel[i] = we && ch == 3'(i);
      qual[i] = run[i] && (I_GATE[i] || !gateen[i]);
      tick[i] = qual[i] && pcnt[i] == pre[i];
      term[i] = tick[i] && count[i] == '0 && !(sel[i] && rsel == 2'd2);
      set_irq[i] = term[i] && ien[i];
      ack[i] = I_IACK && irq[i] && O_VEC == 3'(i);
    end
  end
  always_comb begin
    O_D = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (ch == 3'(i))
        O_D = rsel == 2'd0 ? 16'(reload[i]) :
              rsel == 2'd1 ? 16'({pre[i], 2'b00, gateen[i], oneshot[i], 1'b0, ien[i], run[i], irq[i]}) :
              rsel == 2'd2 ? 16'(count[i]) : '0;
  end
  // Register writes take priority over counting, but never drop an interrupt.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        reload[i] <= '0;
        count[i] <= '0;
        pcnt[i] <= '0;
        pre[i] <= '0;
      end
      irq <= '0;
      run <= '0;
      ien <= '0;
      oneshot <= '0;
      gateen <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel[i] && rsel == 2'd0) reload[i] <= wd;
        if (sel[i] && rsel == 2'd2) count[i] <= wd;
        else if (sel[i] && rsel == 2'd1 && I_D[3]) count[i] <= reload[i];
        else if (tick[i]) count[i] <= count[i] == '0 ? reload[i] : count[i] - TIMER_WIDTH'(1);
        if (sel[i] && rsel == 2'd1 && (I_D[3] || (I_D[1] && !run[i]))) pcnt[i] <= '0;
        else if (qual[i]) pcnt[i] <= tick[i] ? '0 : pcnt[i] + PRE_WIDTH'(1);
        if (sel[i] && rsel == 2'd1) begin
          irq[i] <= I_D[0] | set_irq[i];
          run[i] <= I_D[1];
          ien[i] <= I_D[2];
          oneshot[i] <= I_D[4];
          gateen[i] <= I_D[5];
          pre[i] <= I_D[8 +: PRE_WIDTH];
        end else begin
          irq[i] <= set_irq[i] | (irq[i] & ~ack[i]);
          if (term[i] && oneshot[i]) run[i] <= 1'b0;
        end
      end
    end
  end
endmodule
